// File: rtl/text_buffer_ctl_if.sv
// text_buffer_ctl_if : font lookup, character stream and status signals of the text buffer
// Rev 1.0
`default_nettype none

interface text_buffer_ctl_if;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_char;
  logic        clear;
  logic        busy;
  logic [7:0]  cursor;

  modport slave (
    input  char_yx, char_line, font_data, wr_valid, wr_char, clear,
    output char_pixels, font_addr, wr_ready, busy, cursor
  );

  modport master (
    output char_yx, char_line, font_data, wr_valid, wr_char, clear,
    input  char_pixels, font_addr, wr_ready, busy, cursor
  );
endinterface

`default_nettype wire

// File: rtl/text_buffer_ctl.sv
// text_buffer_ctl : 16x16 character-cell buffer, cursor-driven writer and 1-cycle font responder
// Rev 1.0
`default_nettype none

module text_buffer_ctl #(
  parameter logic [7:0] BLANK   = 8'h20,
  parameter logic [7:0] NL_CODE = 8'h0A,
  parameter logic [7:0] BS_CODE = 8'h08
) (
  input  wire               clk,
  input  wire               rst,
  text_buffer_ctl_if.slave  bus
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mem [256];
  logic [7:0]  r_cursor;
  logic [7:0]  r_clr_addr;
  logic [7:0]  r_pixels;

  logic [7:0]  w_cursor_nxt;
  logic [7:0]  w_clr_nxt;
  logic        w_we;
  logic [7:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic        w_busy;
  logic        w_wr_ready;
  logic [6:0]  w_rd_code;

  // Code bit 7 never reaches the font ROM.
  assign w_rd_code       = r_mem[bus.char_yx][6:0];
  assign bus.font_addr   = {w_rd_code, bus.char_line};
  assign bus.char_pixels = r_pixels;
  assign bus.cursor      = r_cursor;
  assign bus.busy        = w_busy;
  assign bus.wr_ready    = w_wr_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_clr_nxt    = r_clr_addr;
    w_we         = 1'b0;
    w_waddr      = r_clr_addr;
    w_wdata      = BLANK;
    w_busy       = 1'b0;
    w_wr_ready   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy    = 1'b1;
        w_we      = 1'b1;
        w_clr_nxt = r_clr_addr + 8'd1;
        if (r_clr_addr == 8'hFF) begin
          w_state_nxt  = S_IDLE;
          w_cursor_nxt = 8'h00;
          w_clr_nxt    = 8'h00;
        end
      end
      S_IDLE: begin
        w_wr_ready = !bus.clear;
        if (bus.clear) begin
          w_state_nxt = S_CLEAR;
        end else if (bus.wr_valid) begin
          if (bus.wr_char == NL_CODE) begin
            w_cursor_nxt = {r_cursor[7:4] + 4'd1, 4'd0};
          end else if (bus.wr_char == BS_CODE) begin
            if (r_cursor != 8'h00) begin
              w_cursor_nxt = r_cursor - 8'd1;
              w_we         = 1'b1;
              w_waddr      = r_cursor - 8'd1;
              w_wdata      = BLANK;
            end
          end else begin
            w_we         = 1'b1;
            w_waddr      = r_cursor;
            w_wdata      = bus.wr_char;
            w_cursor_nxt = r_cursor + 8'd1;
          end
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_cursor   <= 8'h00;
      r_clr_addr <= 8'h00;
      r_pixels   <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cursor   <= w_cursor_nxt;
      r_clr_addr <= w_clr_nxt;
      r_pixels   <= bus.font_data;
    end
  end

  // Contents are left alone by reset; the sweep that follows blanks them.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_buffer_ctl.sv
// tb_text_buffer_ctl : directed self-checking bench for text_buffer_ctl with a combinational font model
// Rev 1.0
`default_nettype none

module tb_text_buffer_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  text_buffer_ctl_if bus ();

  text_buffer_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font_f(input logic [6:0] c, input logic [3:0] l);
    return ({1'b0, c} * 8'd3) ^ {l, l};
  endfunction

  assign bus.font_data = font_f(bus.font_addr[10:4], bus.font_addr[3:0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] c);
    bus.wr_valid = 1'b1;
    bus.wr_char  = c;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic check_cell(input string tag, input logic [7:0] yx, input logic [6:0] exp);
    bus.char_yx = yx;
    #1;
    check(tag, {25'd0, bus.font_addr[10:4]}, {25'd0, exp});
  endtask

  // Counts edges until busy drops; an optional second clear is pulsed at edge clr_at.
  task automatic sweep_len(input int clr_at, output int n);
    n = 0;
    while (bus.busy && n < 400) begin
      if (n == clr_at) bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      n++;
    end
  endtask

  initial begin
    int n;
    bus.char_yx   = 8'h00;
    bus.char_line = 4'h0;
    bus.wr_valid  = 1'b0;
    bus.wr_char   = 8'h00;
    bus.clear     = 1'b0;

    step();
    step();
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
    check("rst_ready", {31'd0, bus.wr_ready}, 32'd0);
    check("rst_cursor", {24'd0, bus.cursor}, 32'h0);
    check("rst_pixels", {24'd0, bus.char_pixels}, 32'h0);
    rst = 1'b0;

    sweep_len(-1, n);
    check("init_sweep_len", n, 256);
    check("init_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("init_cursor", {24'd0, bus.cursor}, 32'h0);
    check_cell("blank_00", 8'h00, 7'h20);
    check_cell("blank_7c", 8'h7C, 7'h20);
    check_cell("blank_ff", 8'hFF, 7'h20);
    bus.char_yx = 8'hA3; bus.char_line = 4'd9;
    step();
    check("blank_pixels", {24'd0, bus.char_pixels}, {24'd0, font_f(7'h20, 4'd9)});

    wr(8'h41);
    wr(8'h42);
    check("ab_cursor", {24'd0, bus.cursor}, 32'h2);
    check_cell("mem0", 8'h00, 7'h41);
    check_cell("mem1", 8'h01, 7'h42);
    bus.char_yx = 8'h00; bus.char_line = 4'd5;
    step();
    check("latency_A5", {24'd0, bus.char_pixels}, {24'd0, font_f(7'h41, 4'd5)});

    // Read-during-write to cell 2: old code first, new code the cycle after.
    bus.char_yx = 8'h02; bus.char_line = 4'd3;
    wr(8'h43);
    check("rdw_old", {24'd0, bus.char_pixels}, {24'd0, font_f(7'h20, 4'd3)});
    step();
    check("rdw_new", {24'd0, bus.char_pixels}, {24'd0, font_f(7'h43, 4'd3)});

    wr(8'h0A);
    wr(8'h31); wr(8'h32); wr(8'h33);
    check("cursor_13", {24'd0, bus.cursor}, 32'h13);
    wr(8'h0A);
    check("nl_13", {24'd0, bus.cursor}, 32'h20);
    check_cell("nl_nowrite", 8'h13, 7'h20);
    check_cell("cell_12", 8'h12, 7'h33);

    wr(8'hC1);
    check_cell("bit7_ignored", 8'h20, 7'h41);
    for (int i = 0; i < 13; i++) wr(8'h0A);
    for (int i = 0; i < 7; i++) wr(8'h50);
    check("cursor_f7", {24'd0, bus.cursor}, 32'hF7);
    wr(8'h0A);
    check("nl_wrap", {24'd0, bus.cursor}, 32'h00);

    for (int i = 0; i < 15; i++) wr(8'h0A);
    for (int i = 0; i < 15; i++) wr(8'h51);
    check("cursor_ff", {24'd0, bus.cursor}, 32'hFF);
    wr(8'h5A);
    check("char_wrap", {24'd0, bus.cursor}, 32'h00);
    check_cell("mem_ff", 8'hFF, 7'h5A);

    for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
    wr(8'h08);
    check("bs_cursor", {24'd0, bus.cursor}, 32'h04);
    check_cell("bs_blank", 8'h04, 7'h20);
    check_cell("bs_keep3", 8'h03, 7'h64);
    for (int i = 0; i < 4; i++) wr(8'h08);
    wr(8'h08);
    check("bs_at0", {24'd0, bus.cursor}, 32'h00);
    check_cell("bs_at0_ff", 8'hFF, 7'h5A);

    wr(8'h70); wr(8'h71);
    bus.clear = 1'b1; bus.wr_valid = 1'b1; bus.wr_char = 8'h55;
    #1;
    check("clr_ready", {31'd0, bus.wr_ready}, 32'd0);
    step();
    bus.clear = 1'b0; bus.wr_valid = 1'b0;
    check("clr_busy", {31'd0, bus.busy}, 32'd1);
    check("clr_drop", {24'd0, bus.cursor}, 32'h02);
    sweep_len(100, n);
    check("clr_sweep_len", n, 256);
    check("clr_cursor", {24'd0, bus.cursor}, 32'h0);
    check_cell("clr_ff", 8'hFF, 7'h20);
    check_cell("clr_01", 8'h01, 7'h20);

    wr(8'h72); wr(8'h73); wr(8'h74);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < 50; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_cursor", {24'd0, bus.cursor}, 32'h0);
    check("rst2_busy", {31'd0, bus.busy}, 32'd1);
    sweep_len(-1, n);
    check("rst2_sweep_len", n, 256);
    check("rst2_ready", {31'd0, bus.wr_ready}, 32'd1);
    check_cell("rst2_blank", 8'h01, 7'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_buffer_ctl.md
Name: text_buffer_ctl

Overview:
Character-cell text buffer and font responder for the on-screen text rectangle. It serves the character drawer's lookup requests: char_yx and char_line in, char_pixels out with exactly 1-cycle latency, via the external combinational font ROM. It also accepts characters from game logic on a valid/ready stream and writes them at an auto-advancing cursor. A clear sweep blanks the buffer after reset or on command.

Parameters:
BLANK, 8'h20, character code written by clear and backspace
NL_CODE, 8'h0A, newline control code (not stored)
BS_CODE, 8'h08, backspace control code (not stored)

Ports:
clk  in  1  system clock
rst  in  1  reset
char_yx  in  8  {row[3:0], col[3:0]} cell being drawn
char_line  in  4  pixel line within the cell, 0..15
char_pixels  out  8  font row for the requested cell/line, MSB = leftmost pixel
font_addr  out  11  {char_code[6:0], char_line} to the font ROM, combinational
font_data  in  8  font ROM data, combinational function of font_addr
wr_valid  in  1  wr_char valid
wr_ready  out  1  block accepts wr_char this cycle
wr_char  in  8  character or control code
clear  in  1  single-cycle request to blank the buffer
busy  out  1  clear sweep in progress
cursor  out  8  {row, col} of the next write position

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high: char_pixels=0, cursor=0, clr_addr=0, state=CLEAR, so busy=1 and wr_ready=0. Memory contents are not reset directly; the CLEAR sweep blanks them.
- Storage: 256 x 8-bit register array mem, indexed by {row, col}.
- Read path:
  - font_addr = {mem[char_yx][6:0], char_line}, combinational. Bit 7 of the code is ignored.
  - char_pixels <= font_data on every clock edge in every state, including CLEAR.
  - Total latency is 1 cycle: pixels for the char_yx/char_line presented in cycle N are valid in cycle N+1.
  - Read during write to the same cell returns the old code; the new code is visible from the next cycle.
- FSM with states CLEAR and IDLE:
  - CLEAR:
    - busy=1, wr_ready=0.
    - Each cycle writes mem[clr_addr] <= BLANK and increments clr_addr.
    - When clr_addr==255 is written, go to IDLE, set cursor=0 and clr_addr=0.
    - The sweep takes exactly 256 cycles. clear asserted during CLEAR is ignored and does not restart the sweep.
  - IDLE:
    - busy=0. wr_ready = !clear (combinational).
    - If clear=1, go to CLEAR next cycle; no write happens that cycle.
    - On accept (wr_valid && wr_ready):
      - wr_char==NL_CODE: cursor <= {row+1, 4'd0}; row 15 wraps to 0; no memory write.
      - wr_char==BS_CODE: if cursor!=0, cursor <= cursor-1 and mem[cursor-1] <= BLANK; if cursor==0, no change.
      - Otherwise: mem[cursor] <= wr_char; cursor <= cursor+1; 8-bit wrap, 255 -> 0 (row 15 col 15 -> row 0 col 0).
- No back-pressure from the read side; the read path never stalls.
- Reset mid-sweep or mid-stream: the next cycle restarts CLEAR from clr_addr=0 with cursor=0.

Test Plan:
- Reset, then hold rst low: busy=1 for exactly 256 cycles, then busy=0, wr_ready=1, cursor=0. Every cell reads 8'h20, so with a font model font_addr[10:4]=7'h20 for any char_yx.
- Write "A" (8'h41) then "B" (8'h42) from cursor 0 -> cursor=2; mem[0]=8'h41, mem[1]=8'h42. char_yx=0, char_line=5 in cycle N -> char_pixels = font(0x41, 5) in cycle N+1.
- Write 8'h0A at cursor 8'h13 -> cursor=8'h20, no memory change. Write 8'h0A at cursor 8'hF7 -> cursor=8'h00.
- Write 8'h5A at cursor 8'hFF -> mem[255]=8'h5A, cursor=8'h00. Write 8'h08 at cursor 8'h05 -> cursor=8'h04, mem[4]=8'h20. Write 8'h08 at cursor 0 -> no change.
- Assert clear with wr_valid=1 in the same cycle -> wr_ready=0, write dropped, busy=1 next cycle. A second clear 100 cycles in -> sweep still ends 256 cycles after the first.
- Pulse rst at cycle 50 of a sweep -> sweep restarts from clr_addr=0; busy falls exactly 256 cycles after rst deasserts.
